// File: rtl/gb_pkg.sv
// Shared Game Boy constants, DMA FSM state type and page-mapping helpers.
package gb_pkg;

    localparam logic [15:0] ADDR_OAM_BASE = 16'hFE00;
    localparam logic [15:0] ADDR_DMA_REG  = 16'hFF46;
    localparam int unsigned OAM_BYTES     = 160;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    // Echo RAM pages (E0-FF) fold back onto work RAM (C0-DF).
    function automatic logic [7:0] eff_page(input logic [7:0] page);
        return (page >= 8'hE0) ? (page & 8'hDF) : page;
    endfunction

    // Pages served by the cartridge: ROM (00-7F) and external RAM (A0-BF).
    function automatic logic is_cart_page(input logic [7:0] page);
        return (page < 8'h80) || ((page >= 8'hA0) && (page <= 8'hBF));
    endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA initiator: a write to FF46 copies DMA_LEN bytes from page {FF46,00} into OAM,
// one byte per CYCLES_PER_BYTE clocks, while blocking the CPU bus.
module oam_dma_ctrl
    import gb_pkg::*;
#(
    parameter int unsigned DMA_LEN         = OAM_BYTES,
    parameter int unsigned CYCLES_PER_BYTE = 4,
    parameter int unsigned START_DELAY     = 4,
    parameter logic [15:0] REG_ADDR        = ADDR_DMA_REG
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reg_wr_en,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_wr_data,
    output logic [7:0]  reg_rd_data,
    input  logic [7:0]  dma_rd_data,
    output logic [15:0] address_bus_dma_rd,
    output logic        dma_sel_cart_rom,
    output logic        oam_wr_en,
    output logic [7:0]  oam_wr_addr,
    output logic [7:0]  oam_wr_data,
    output logic        dma_active,
    output logic        cpu_bus_block
);

    localparam int unsigned PHASE_W = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam int unsigned DLY_W   = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(CYCLES_PER_BYTE - 1);
    localparam logic [DLY_W-1:0]   DLY_INIT   = DLY_W'(START_DELAY - 1);
    localparam logic [7:0]         LAST_BYTE  = 8'(DMA_LEN - 1);

    // The read-data latch in phase 1 and the write in the last phase need distinct clocks.
    if (CYCLES_PER_BYTE < 3) begin : g_bad_cpb
        $error("oam_dma_ctrl: CYCLES_PER_BYTE must be >= 3");
    end

    dma_state_t         state, state_nxt;
    logic [DLY_W-1:0]   delay_cnt, delay_nxt;
    logic [7:0]         byte_cnt, byte_nxt;
    logic [PHASE_W-1:0] phase, phase_nxt;
    logic [7:0]         src_page, page_nxt;
    logic [7:0]         rd_latch, latch_nxt;
    logic [7:0]         rd_data_nxt;
    logic               trigger;

    logic [7:0]  eff_nxt;
    logic [15:0] addr_nxt;
    logic        sel_nxt;
    logic        wr_en_nxt;
    logic [7:0]  wr_addr_nxt;
    logic [7:0]  wr_data_nxt;
    logic        active_nxt;

    assign trigger = reg_wr_en && (reg_addr == REG_ADDR);

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            delay_cnt          <= '0;
            byte_cnt           <= '0;
            phase              <= '0;
            src_page           <= '0;
            rd_latch           <= '0;
            reg_rd_data        <= '0;
            address_bus_dma_rd <= '0;
            dma_sel_cart_rom   <= 1'b0;
            oam_wr_en          <= 1'b0;
            oam_wr_addr        <= '0;
            oam_wr_data        <= '0;
            dma_active         <= 1'b0;
        end else begin
            state              <= state_nxt;
            delay_cnt          <= delay_nxt;
            byte_cnt           <= byte_nxt;
            phase              <= phase_nxt;
            src_page           <= page_nxt;
            rd_latch           <= latch_nxt;
            reg_rd_data        <= rd_data_nxt;
            address_bus_dma_rd <= addr_nxt;
            dma_sel_cart_rom   <= sel_nxt;
            oam_wr_en          <= wr_en_nxt;
            oam_wr_addr        <= wr_addr_nxt;
            oam_wr_data        <= wr_data_nxt;
            dma_active         <= active_nxt;
        end
    end

    // Next state; a trigger restarts from DELAY regardless of the current state.
    always_comb begin : next_state_comb
        state_nxt   = state;
        delay_nxt   = delay_cnt;
        byte_nxt    = byte_cnt;
        phase_nxt   = phase;
        page_nxt    = src_page;
        rd_data_nxt = reg_rd_data;
        latch_nxt   = rd_latch;

        if ((state == XFER) && (phase == PHASE_W'(1))) begin
            latch_nxt = dma_rd_data;
        end

        if (trigger) begin
            state_nxt   = DELAY;
            delay_nxt   = DLY_INIT;
            byte_nxt    = '0;
            phase_nxt   = '0;
            page_nxt    = reg_wr_data;
            rd_data_nxt = reg_wr_data;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                DELAY: begin
                    if (delay_cnt == '0) begin
                        state_nxt = XFER;
                        byte_nxt  = '0;
                        phase_nxt = '0;
                    end else begin
                        delay_nxt = delay_cnt - DLY_W'(1);
                    end
                end
                XFER: begin
                    if (phase == LAST_PHASE) begin
                        phase_nxt = '0;
                        if (byte_cnt == LAST_BYTE) begin
                            state_nxt = IDLE;
                            byte_nxt  = '0;
                        end else begin
                            byte_nxt = byte_cnt + 8'd1;
                        end
                    end else begin
                        phase_nxt = phase + PHASE_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    byte_nxt  = '0;
                    phase_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin : output_comb
        eff_nxt     = eff_page(page_nxt);
        addr_nxt    = '0;
        sel_nxt     = 1'b0;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = '0;
        wr_data_nxt = '0;
        active_nxt  = (state_nxt != IDLE);

        if (state_nxt == XFER) begin
            addr_nxt = {eff_nxt, byte_nxt};
            sel_nxt  = is_cart_page(eff_nxt);
            if (phase_nxt == LAST_PHASE) begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = byte_nxt;
                wr_data_nxt = latch_nxt;
            end
        end
    end

    assign cpu_bus_block = dma_active;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: table-driven pages, random pages/restarts,
// and hand-written restart / reset / stray-register-write sequences.
module tb_oam_dma_ctrl;

    localparam int CPB      = 4;
    localparam int SD       = 4;
    localparam int LEN      = 160;
    localparam int ACT_CLKS = SD + LEN * CPB;
    localparam int RUN_CLKS = ACT_CLKS + 6;

    logic        clock;
    logic        reset;
    logic        reg_wr_en;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wr_data;
    logic [7:0]  reg_rd_data;
    logic [7:0]  dma_rd_data;
    logic [15:0] address_bus_dma_rd;
    logic        dma_sel_cart_rom;
    logic        oam_wr_en;
    logic [7:0]  oam_wr_addr;
    logic [7:0]  oam_wr_data;
    logic        dma_active;
    logic        cpu_bus_block;

    oam_dma_ctrl #(
        .DMA_LEN        (LEN),
        .CYCLES_PER_BYTE(CPB),
        .START_DELAY    (SD),
        .REG_ADDR       (16'hFF46)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .reg_wr_en         (reg_wr_en),
        .reg_addr          (reg_addr),
        .reg_wr_data       (reg_wr_data),
        .reg_rd_data       (reg_rd_data),
        .dma_rd_data       (dma_rd_data),
        .address_bus_dma_rd(address_bus_dma_rd),
        .dma_sel_cart_rom  (dma_sel_cart_rom),
        .oam_wr_en         (oam_wr_en),
        .oam_wr_addr       (oam_wr_addr),
        .oam_wr_data       (oam_wr_data),
        .dma_active        (dma_active),
        .cpu_bus_block     (cpu_bus_block)
    );

    logic [7:0] mem [0:65535];
    logic [7:0] oam [0:LEN-1];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory system: registered read, data one clock after the address.
    initial dma_rd_data = 8'h00;
    always @(posedge clock) dma_rd_data <= mem[address_bus_dma_rd];

    int n_checks = 0;
    int n_errors = 0;

    // Reference-model state: cycle of the last trigger and what it asked for.
    int         cyc = 0;
    int         t0 = 0;
    bit         running = 1'b0;
    logic [7:0] cur_hi = 8'h00;
    logic       cur_sel = 1'b0;
    logic [7:0] cur_reg = 8'h00;

    int act_bad, addr_bad, sel_bad, wr_bad, rd_bad, wr_cnt, exp_wr_cnt;

    typedef struct {
        logic [7:0] page;
        logic [7:0] base_hi;
        logic       sel;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] m_eff(input logic [7:0] p);
        return (p >= 8'd224) ? p - 8'd32 : p;
    endfunction

    function automatic logic m_sel(input logic [7:0] p);
        logic [7:0] e;
        e = m_eff(p);
        return (e < 8'd128) || (e >= 8'd160 && e < 8'd192);
    endfunction

    task automatic step();
        @(posedge clock);
        cyc++;
        @(negedge clock);
        reg_wr_en   = 1'b0;
        reg_addr    = 16'h0000;
        reg_wr_data = 8'h00;
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
        reg_wr_en   = 1'b1;
        reg_addr    = a;
        reg_wr_data = d;
    endtask

    task automatic trigger(input logic [7:0] page, input logic [7:0] hi, input logic sel);
        write_reg(16'hFF46, page);
        t0      = cyc;
        running = 1'b1;
        cur_hi  = hi;
        cur_sel = sel;
        cur_reg = page;
    endtask

    task automatic clear_window();
        act_bad = 0; addr_bad = 0; sel_bad = 0; wr_bad = 0; rd_bad = 0;
        wr_cnt = 0; exp_wr_cnt = 0;
        for (int i = 0; i < LEN; i++) oam[i] = 8'hxx;
    endtask

    // Expected behaviour for this cycle, derived from the time since the last trigger.
    task automatic check_cycle();
        int         k, b, ph;
        bit         act, xf, we;
        logic [15:0] ea;
        k   = cyc - t0;
        act = running && (k >= 1) && (k <= ACT_CLKS);
        xf  = running && (k >= 1 + SD) && (k <= ACT_CLKS);
        b   = xf ? (k - 1 - SD) / CPB : 0;
        ph  = xf ? (k - 1 - SD) % CPB : 0;
        ea  = xf ? {cur_hi, 8'(b)} : 16'h0000;
        we  = xf && (ph == CPB - 1);
        if (dma_active !== act) act_bad++;
        if (cpu_bus_block !== act) act_bad++;
        if (address_bus_dma_rd !== ea) addr_bad++;
        if (dma_sel_cart_rom !== (xf && cur_sel)) sel_bad++;
        if (oam_wr_en !== we) wr_bad++;
        else if (we && (oam_wr_addr !== 8'(b) || oam_wr_data !== mem[ea])) wr_bad++;
        if (we) exp_wr_cnt++;
        if (oam_wr_en === 1'b1) begin
            wr_cnt++;
            if (oam_wr_addr < 8'(LEN)) oam[oam_wr_addr] = oam_wr_data;
        end
        if (reg_rd_data !== cur_reg) rd_bad++;
    endtask

    task automatic run(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            step();
            check_cycle();
            if (noise && i == 100) write_reg(16'hFF47, 8'($urandom));
            if (noise && i == 101) write_reg(16'hFF45, 8'($urandom));
        end
    endtask

    task automatic finish_window(input string tag, input bit full);
        int oam_bad;
        check({tag, "_active"}, act_bad, 0);
        check({tag, "_addr"}, addr_bad, 0);
        check({tag, "_sel"}, sel_bad, 0);
        check({tag, "_wr"}, wr_bad, 0);
        check({tag, "_rdback"}, rd_bad, 0);
        check({tag, "_wrcount"}, wr_cnt, exp_wr_cnt);
        if (full) begin
            oam_bad = 0;
            for (int i = 0; i < LEN; i++) begin
                logic [15:0] a;
                a = {cur_hi, 8'(i)};
                if (oam[i] !== mem[a]) oam_bad++;
            end
            check({tag, "_oam"}, oam_bad, 0);
        end
    endtask

    task automatic full_run(input string tag, input logic [7:0] page, input logic [7:0] hi,
                            input logic sel, input bit noise);
        clear_window();
        trigger(page, hi, sel);
        run(RUN_CLKS, noise);
        finish_window(tag, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] p, p2;
        int         r;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        vecs[0]  = '{8'hC1, 8'hC1, 1'b0};
        vecs[1]  = '{8'h40, 8'h40, 1'b1};
        vecs[2]  = '{8'hA2, 8'hA2, 1'b1};
        vecs[3]  = '{8'hE3, 8'hC3, 1'b0};
        vecs[4]  = '{8'h00, 8'h00, 1'b1};
        vecs[5]  = '{8'h7F, 8'h7F, 1'b1};
        vecs[6]  = '{8'h80, 8'h80, 1'b0};
        vecs[7]  = '{8'h9F, 8'h9F, 1'b0};
        vecs[8]  = '{8'hBF, 8'hBF, 1'b1};
        vecs[9]  = '{8'hC0, 8'hC0, 1'b0};
        vecs[10] = '{8'hDF, 8'hDF, 1'b0};
        vecs[11] = '{8'hE0, 8'hC0, 1'b0};
        vecs[12] = '{8'hFF, 8'hDF, 1'b0};

        reg_wr_en   = 1'b0;
        reg_addr    = 16'h0000;
        reg_wr_data = 8'h00;
        reset       = 1'b0;
        #1 reset    = 1'b1;
        clear_window();
        run(3, 1'b0);
        check("rst_active", dma_active, 0);
        check("rst_block", cpu_bus_block, 0);
        check("rst_addr", address_bus_dma_rd, 0);
        check("rst_wr_en", oam_wr_en, 0);
        check("rst_rdback", reg_rd_data, 0);
        reset = 1'b0;
        run(3, 1'b0);
        finish_window("idle", 1'b0);

        // Page table: address mapping, cartridge select and OAM contents per page.
        for (int i = 0; i < 13; i++) begin
            full_run($sformatf("page_%02h", vecs[i].page), vecs[i].page, vecs[i].base_hi,
                     vecs[i].sel, i == 0);
        end

        // Random pages, with stray writes to neighbouring registers mid-transfer.
        for (int i = 0; i < 4; i++) begin
            p = 8'($urandom);
            full_run($sformatf("rand_%02h", p), p, m_eff(p), m_sel(p), 1'b1);
        end

        // Retrigger with D0 so the trigger lands on byte 50's write clock.
        clear_window();
        trigger(8'hC0, 8'hC0, 1'b0);
        run(1 + SD + 50 * CPB + (CPB - 2), 1'b0);
        trigger(8'hD0, 8'hD0, 1'b0);
        run(1, 1'b0);
        check("restart_no_wr", oam_wr_en, 0);
        check("restart_active", dma_active, 1);
        run(RUN_CLKS - 1, 1'b0);
        finish_window("restart_d0", 1'b1);

        // Random restart point and random pages.
        clear_window();
        p  = 8'($urandom);
        p2 = 8'($urandom);
        r  = $urandom_range(2, ACT_CLKS - 2);
        trigger(p, m_eff(p), m_sel(p));
        run(r, 1'b0);
        trigger(p2, m_eff(p2), m_sel(p2));
        run(RUN_CLKS, 1'b0);
        finish_window("restart_rand", 1'b1);

        // Asynchronous reset during byte 80.
        clear_window();
        trigger(8'hC1, 8'hC1, 1'b0);
        run(1 + SD + 80 * CPB, 1'b0);
        finish_window("pre_reset", 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_active", dma_active, 0);
        check("mid_rst_block", cpu_bus_block, 0);
        check("mid_rst_addr", address_bus_dma_rd, 0);
        check("mid_rst_sel", dma_sel_cart_rom, 0);
        check("mid_rst_wr_en", oam_wr_en, 0);
        check("mid_rst_wr_addr", oam_wr_addr, 0);
        check("mid_rst_wr_data", oam_wr_data, 0);
        check("mid_rst_rdback", reg_rd_data, 0);
        running = 1'b0;
        cur_reg = 8'h00;
        clear_window();
        run(2, 1'b0);
        reset = 1'b0;
        run(4, 1'b0);
        finish_window("post_reset_idle", 1'b0);
        p = 8'($urandom);
        full_run("after_reset", p, m_eff(p), m_sel(p), 1'b0);

        // Writes to FF47/FF45 while idle change nothing; readback keeps the last trigger.
        clear_window();
        write_reg(16'hFF47, 8'h55);
        run(1, 1'b0);
        write_reg(16'hFF45, 8'hAA);
        run(6, 1'b0);
        finish_window("idle_noise", 1'b0);
        check("idle_rdback", reg_rd_data, p);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
